// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 responder that serves bursts from a word-addressed,
// single-port synchronous SRAM with one cycle of read latency.
// One transaction is in flight at a time. When reads and writes are both
// pending, they alternate, and a read goes first after reset.
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. A valid raised by this block stays high,
// with its payload stable, until the matching ready is seen.
module axi_sram_slave #(
  parameter int unsigned MEM_AW = 16,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  // read address channel
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  // read data channel
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // write address channel
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  // write data channel
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // write response channel
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // SRAM port
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  // debug: current FSM state
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] RD_DATA = 3'd3;
  localparam logic [2:0] WR_DATA = 3'd4;
  localparam logic [2:0] WR_RESP = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Size of the mapped window in bytes, one bit wider than any 33-bit offset.
  localparam logic [33:0] SPAN = 34'd1 << (MEM_AW + 2);

  logic [2:0]        state, state_n;
  logic              rd_prio;      // 1: a read wins when both sides are pending
  logic [3:0]        id_q;
  logic [31:0]       addr_q;
  logic [3:0]        len_q;
  logic [3:0]        beat_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic              wr_dec;       // some write beat fell outside the window
  logic              wr_slv;       // wlast or wid disagreed with the burst

  logic [32:0]       offset;
  logic              in_range;
  logic [MEM_AW-1:0] word_idx;
  logic [31:0]       addr_next;
  logic              last_beat;
  logic              sel_rd, sel_wr;
  logic              accept_rd, accept_wr;
  logic              unused_inputs;

  // The borrow bit of the 33-bit subtraction flags addresses below BASE.
  assign offset    = {1'b0, addr_q} - {1'b0, BASE};
  assign in_range  = !offset[32] && ({1'b0, offset} < SPAN);
  assign word_idx  = offset[MEM_AW+1:2];
  // FIXED holds the address; INCR, WRAP and the reserved encoding all step.
  assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);
  assign last_beat = (beat_q == len_q);

  // The side not served last wins when both request at once.
  assign sel_rd = arvalid && (!awvalid || rd_prio);
  assign sel_wr = awvalid && !sel_rd;

  assign dbg_state     = state;
  assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot};

  // Next-state logic and all channel/SRAM outputs; outputs outside their state are 0.
  always_comb begin
    state_n   = state;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    arready   = 1'b0;
    awready   = 1'b0;
    rid       = 4'd0;
    rdata     = 32'd0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    rvalid    = 1'b0;
    wready    = 1'b0;
    bid       = 4'd0;
    bresp     = 2'b00;
    bvalid    = 1'b0;
    mem_en    = 1'b0;
    mem_wen   = 4'd0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    case (state)
      IDLE: begin
        if (sel_rd) begin
          arready   = 1'b1;
          accept_rd = 1'b1;
          state_n   = RD_REQ;
        end else if (sel_wr) begin
          awready   = 1'b1;
          accept_wr = 1'b1;
          state_n   = WR_DATA;
        end
      end
      RD_REQ: begin
        mem_en   = in_range;
        mem_addr = word_idx;
        state_n  = RD_WAIT;
      end
      RD_WAIT: begin
        state_n = RD_DATA;
      end
      RD_DATA: begin
        rvalid = 1'b1;
        rid    = id_q;
        rdata  = rdata_q;
        rresp  = rresp_q;
        rlast  = last_beat;
        if (rready) begin
          state_n = last_beat ? IDLE : RD_REQ;
        end
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_en    = in_range;
          mem_wen   = in_range ? wstrb : 4'd0;
          mem_addr  = word_idx;
          mem_wdata = wdata;
          if (last_beat) begin
            state_n = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = wr_dec ? RESP_DECERR : (wr_slv ? RESP_SLVERR : RESP_OKAY);
        if (bready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register plus burst bookkeeping: latch on accept, step on each beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rd_prio <= 1'b1;
      id_q    <= 4'd0;
      addr_q  <= 32'd0;
      len_q   <= 4'd0;
      beat_q  <= 4'd0;
      size_q  <= 3'd0;
      burst_q <= 2'b00;
      rdata_q <= 32'd0;
      rresp_q <= 2'b00;
      wr_dec  <= 1'b0;
      wr_slv  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept_rd) begin
        id_q    <= arid;
        addr_q  <= araddr;
        len_q   <= arlen;
        size_q  <= arsize;
        burst_q <= arburst;
        beat_q  <= 4'd0;
        rd_prio <= 1'b0;
      end
      if (accept_wr) begin
        id_q    <= awid;
        addr_q  <= awaddr;
        len_q   <= awlen;
        size_q  <= awsize;
        burst_q <= awburst;
        beat_q  <= 4'd0;
        wr_dec  <= 1'b0;
        wr_slv  <= 1'b0;
        rd_prio <= 1'b1;
      end
      case (state)
        RD_WAIT: begin
          // The address has not moved since RD_REQ, so in_range still
          // describes the beat whose data is arriving now.
          rdata_q <= in_range ? mem_rdata : 32'd0;
          rresp_q <= in_range ? RESP_OKAY : RESP_DECERR;
        end
        RD_DATA: begin
          if (rready && !last_beat) begin
            beat_q <= beat_q + 4'd1;
            addr_q <= addr_next;
          end
        end
        WR_DATA: begin
          if (wvalid) begin
            if (!in_range) begin
              wr_dec <= 1'b1;
            end
            if ((wlast != last_beat) || (wid != id_q)) begin
              wr_slv <= 1'b1;
            end
            if (!last_beat) begin
              beat_q <= beat_q + 4'd1;
              addr_q <= addr_next;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized self-checking bench for axi_sram_slave.
// A behavioural SRAM sits on the memory port; a separate reference memory and
// address-rule functions predict every beat, response and SRAM strobe.
module tb_axi_sram_slave;

  localparam int          MEM_AW = 8;
  localparam logic [31:0] BASE   = 32'h0000_2000;
  localparam int          WORDS  = 1 << MEM_AW;
  localparam logic [31:0] SPAN_B = 32'(4 * WORDS);

  logic clk = 1'b0;
  logic reset;
  logic [3:0] arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata, mem_wdata, mem_rdata;
  logic [3:0] arlen, awlen, arcache, awcache, wstrb, mem_wen;
  logic [2:0] arsize, awsize, arprot, awprot, dbg_state;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready, mem_en;
  logic [MEM_AW-1:0] mem_addr;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int mem_en_cnt = 0;

  logic [31:0] sram    [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic [31:0] w_data  [16];
  logic [3:0]  w_strb  [16];

  axi_sram_slave #(.MEM_AW(MEM_AW), .BASE(BASE)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port SRAM with one cycle of read latency
  always @(posedge clk) begin
    if (mem_en) begin
      for (int k = 0; k < 4; k++)
        if (mem_wen[k]) sram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      mem_rdata  <= sram[mem_addr];
      mem_en_cnt <= mem_en_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- reference rules ----------------
  function automatic bit in_rng(input logic [31:0] a);
    longint d;
    d = longint'(a) - longint'(BASE);
    return (d >= 0) && (d < longint'(SPAN_B));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] step(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bu);
    return (bu == 2'b00) ? a : a + (32'd1 << sz);
  endfunction

  // ---------------- drivers ----------------
  task automatic init_inputs;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 0; arcache = 0; arprot = 0;
    arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 0; awcache = 0; awprot = 0;
    awvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
  endtask

  task automatic apply_reset;
    init_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] sz, input logic [1:0] bu, output int t_hs, output bit ok);
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    arlock = 2'($urandom_range(0, 3)); arcache = 4'($urandom_range(0, 15));
    ok = 0; t_hs = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (arready) begin ok = 1; t_hs = cyc; break; end
    end
    @(posedge clk); #1 arvalid = 1'b0;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL ar_handshake timeout got arready=0 want 1"); end
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] sz, input logic [1:0] bu, output bit ok);
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    awprot = 3'($urandom_range(0, 7));
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (awready) begin ok = 1; break; end
    end
    @(posedge clk); #1 awvalid = 1'b0;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL aw_handshake timeout got awready=0 want 1"); end
  endtask

  // Full read burst: predicts beats from ref_mem, optionally stalls one beat.
  task automatic do_read(input string name, input logic [3:0] id, input logic [31:0] a0,
                         input logic [3:0] len, input logic [2:0] sz, input logic [1:0] bu,
                         input int stall_beat, input int stall_len);
    logic [31:0] exp_d[$];
    logic [1:0]  exp_r[$];
    logic [31:0] a;
    int exp_en, en0, t_hs, waited;
    bit ok;
    a = a0; exp_en = 0;
    for (int b = 0; b <= int'(len); b++) begin
      if (in_rng(a)) begin exp_d.push_back(ref_mem[widx(a)]); exp_r.push_back(2'b00); exp_en++; end
      else begin exp_d.push_back(32'd0); exp_r.push_back(2'b11); end
      a = step(a, sz, bu);
    end
    en0 = mem_en_cnt;
    ar_send(id, a0, len, sz, bu, t_hs, ok);
    if (!ok) return;
    for (int b = 0; b <= int'(len); b++) begin
      rready = (b == stall_beat) ? 1'b0 : 1'b1;
      waited = 0;
      @(negedge clk);
      while (!rvalid && waited < 20) begin @(negedge clk); waited++; end
      tests_run++;
      if (!rvalid) begin
        tests_failed++; rready = 1'b0;
        $display("FAIL %s rvalid_timeout beat %0d got 0 want 1", name, b);
        return;
      end
      if (b == 0) begin
        tests_run++;
        if (cyc - t_hs != 3) begin
          tests_failed++;
          $display("FAIL %s first_rvalid_latency got %0d want 3", name, cyc - t_hs);
        end
      end
      if (rdata !== exp_d[b] || rresp !== exp_r[b] || rid !== id || rlast !== (b == int'(len))) begin
        tests_failed++;
        $display("FAIL %s beat %0d got data=%h resp=%0d id=%0d last=%0d want data=%h resp=%0d id=%0d last=%0d",
                 name, b, rdata, rresp, rid, rlast, exp_d[b], exp_r[b], id, (b == int'(len)));
      end
      if (b == stall_beat) begin
        for (int k = 0; k < stall_len; k++) begin
          @(posedge clk); #1;
          @(negedge clk);
          tests_run++;
          if (rvalid !== 1'b1 || rdata !== exp_d[b] || rresp !== exp_r[b] || rlast !== (b == int'(len))) begin
            tests_failed++;
            $display("FAIL %s stall_hold beat %0d got valid=%0d data=%h last=%0d want valid=1 data=%h last=%0d",
                     name, b, rvalid, rdata, rlast, exp_d[b], (b == int'(len)));
          end
        end
        @(posedge clk); #1 rready = 1'b1;
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    tests_run++;
    if (mem_en_cnt - en0 != exp_en) begin
      tests_failed++;
      $display("FAIL %s mem_en_count got %0d want %0d", name, mem_en_cnt - en0, exp_en);
    end
  endtask

  // Full write burst from w_data/w_strb; may corrupt wlast or wid on one beat.
  task automatic do_write(input string name, input logic [3:0] id, input logic [31:0] a0,
                          input logic [3:0] len, input logic [2:0] sz, input logic [1:0] bu,
                          input int wlast_bad, input int wid_bad);
    logic [31:0] a;
    logic [1:0] exp_b;
    logic [3:0] exp_wen;
    logic [MEM_AW-1:0] exp_idx;
    bit dec, slv, ok, inr;
    int exp_en, en0, waited;
    a = a0; dec = 0; slv = 0; exp_en = 0;
    en0 = mem_en_cnt;
    aw_send(id, a0, len, sz, bu, ok);
    if (!ok) return;
    for (int b = 0; b <= int'(len); b++) begin
      inr = in_rng(a);
      wid    = (b == wid_bad) ? (id ^ 4'h1) : id;
      wdata  = w_data[b];
      wstrb  = w_strb[b];
      wlast  = (b == int'(len)) ^ (b == wlast_bad);
      wvalid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!wready && waited < 20) begin @(negedge clk); waited++; end
      tests_run++;
      if (!wready) begin
        tests_failed++; wvalid = 1'b0;
        $display("FAIL %s wready_timeout beat %0d got 0 want 1", name, b);
        return;
      end
      exp_wen = inr ? w_strb[b] : 4'd0;
      exp_idx = inr ? MEM_AW'(widx(a)) : '0;
      if (mem_en !== inr || mem_wen !== exp_wen ||
          (inr && (mem_addr !== exp_idx || mem_wdata !== w_data[b]))) begin
        tests_failed++;
        $display("FAIL %s sram_beat %0d got en=%0d wen=%b addr=%0d wdata=%h want en=%0d wen=%b addr=%0d wdata=%h",
                 name, b, mem_en, mem_wen, mem_addr, mem_wdata, inr, exp_wen, exp_idx, w_data[b]);
      end
      if (inr) begin
        exp_en++;
        for (int k = 0; k < 4; k++)
          if (w_strb[b][k]) ref_mem[widx(a)][8*k +: 8] = w_data[b][8*k +: 8];
      end else begin
        dec = 1;
      end
      if (b == wlast_bad || b == wid_bad) slv = 1;
      a = step(a, sz, bu);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    exp_b = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    waited = 0;
    @(negedge clk);
    while (!bvalid && waited < 20) begin @(negedge clk); waited++; end
    tests_run++;
    if (bvalid !== 1'b1 || bid !== id || bresp !== exp_b) begin
      tests_failed++;
      $display("FAIL %s bresp got valid=%0d id=%0d resp=%0d want valid=1 id=%0d resp=%0d",
               name, bvalid, bid, bresp, id, exp_b);
    end
    @(posedge clk); #1 bready = 1'b0;
    tests_run++;
    if (mem_en_cnt - en0 != exp_en) begin
      tests_failed++;
      $display("FAIL %s mem_en_count got %0d want %0d", name, mem_en_cnt - en0, exp_en);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    apply_reset();
    @(negedge clk);
    tests_run++;
    if ({arready, awready, rvalid, wready, bvalid, rlast, mem_en} !== 7'd0 || dbg_state !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl got rdy/vld/en=%b state=%0d want 0000000 state=0",
               {arready, awready, rvalid, wready, bvalid, rlast, mem_en}, dbg_state);
    end
    tests_run++;
    if (rid !== 0 || rdata !== 0 || rresp !== 0 || bid !== 0 || bresp !== 0 || mem_wen !== 0) begin
      tests_failed++;
      $display("FAIL reset_data got rid=%0d rdata=%h rresp=%0d bid=%0d bresp=%0d wen=%b want all 0",
               rid, rdata, rresp, bid, bresp, mem_wen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_basic;
    for (int i = 0; i < 4; i++) begin
      sram[4 + i]    = 32'h11 * (i + 1);
      ref_mem[4 + i] = 32'h11 * (i + 1);
    end
    do_read("rd_basic", 4'h3, BASE + 32'h10, 4'd3, 3'd2, 2'b01, -1, 0);
    do_read("rd_fixed", 4'hC, BASE + 32'h18, 4'd2, 3'd2, 2'b00, -1, 0);
  endtask

  task automatic test_write_strobe;
    w_data[0] = 32'hAABBCCDD; w_strb[0] = 4'b0011;
    w_data[1] = 32'h11223344; w_strb[1] = 4'b1100;
    do_write("wr_strobe", 4'h9, BASE + 32'h8, 4'd1, 3'd2, 2'b01, -1, -1);
    w_data[0] = 32'hDEADBEEF; w_strb[0] = 4'b0000;
    do_write("wr_zero_strobe", 4'hA, BASE + 32'hC, 4'd0, 3'd2, 2'b01, -1, -1);
    do_read("wr_readback", 4'h2, BASE + 32'h8, 4'd1, 3'd2, 2'b01, -1, 0);
  endtask

  task automatic test_stall;
    do_read("rd_stall", 4'h7, BASE + 32'h40, 4'd3, 3'd2, 2'b01, 1, 5);
  endtask

  task automatic test_arbitration;
    int waited;
    logic [31:0] d;
    apply_reset();
    arid = 4'h5; araddr = BASE + 32'h20; arlen = 0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    awid = 4'h6; awaddr = BASE + 32'h24; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    tests_run++;
    if (arready !== 1'b1 || awready !== 1'b0) begin
      tests_failed++; $display("FAIL arb_first got ar=%0d aw=%0d want ar=1 aw=0", arready, awready);
    end
    @(posedge clk); #1 arvalid = 1'b0; rready = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!rvalid && waited < 20) begin @(negedge clk); waited++; end
    tests_run++;
    if (rvalid !== 1'b1 || rdata !== ref_mem[8] || rid !== 4'h5) begin
      tests_failed++; $display("FAIL arb_read1 got valid=%0d data=%h want valid=1 data=%h", rvalid, rdata, ref_mem[8]);
    end
    @(posedge clk); #1 rready = 1'b0; arvalid = 1'b1;
    @(negedge clk);
    tests_run++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      tests_failed++; $display("FAIL arb_second got ar=%0d aw=%0d want ar=0 aw=1", arready, awready);
    end
    @(posedge clk); #1 awvalid = 1'b0;
    d = $urandom;
    wid = 4'h6; wdata = d; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!wready && waited < 20) begin @(negedge clk); waited++; end
    @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    ref_mem[9] = d;
    waited = 0;
    @(negedge clk);
    while (!bvalid && waited < 20) begin @(negedge clk); waited++; end
    tests_run++;
    if (bvalid !== 1'b1 || bid !== 4'h6 || bresp !== 2'b00) begin
      tests_failed++; $display("FAIL arb_write got valid=%0d id=%0d resp=%0d want 1/6/0", bvalid, bid, bresp);
    end
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (arready !== 1'b1 || awready !== 1'b0) begin
      tests_failed++; $display("FAIL arb_third got ar=%0d aw=%0d want ar=1 aw=0", arready, awready);
    end
    @(posedge clk); #1 arvalid = 1'b0; rready = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!rvalid && waited < 20) begin @(negedge clk); waited++; end
    tests_run++;
    if (rvalid !== 1'b1 || rdata !== ref_mem[8]) begin
      tests_failed++; $display("FAIL arb_read2 got valid=%0d data=%h want valid=1 data=%h", rvalid, rdata, ref_mem[8]);
    end
    @(posedge clk); #1 rready = 1'b0;
    do_read("arb_wr_check", 4'h1, BASE + 32'h24, 4'd0, 3'd2, 2'b01, -1, 0);
  endtask

  task automatic test_boundary;
    do_read("rd_edge", 4'h1, BASE + SPAN_B - 32'd4, 4'd1, 3'd2, 2'b01, -1, 0);
    do_read("rd_below_base", 4'hE, BASE - 32'd4, 4'd1, 3'd2, 2'b01, -1, 0);
    for (int b = 0; b < 2; b++) begin w_data[b] = $urandom; w_strb[b] = 4'hF; end
    do_write("wr_early_wlast", 4'h4, BASE + 32'h30, 4'd1, 3'd2, 2'b01, 0, -1);
    do_write("wr_bad_wid", 4'h8, BASE + 32'h50, 4'd1, 3'd2, 2'b01, -1, 1);
    do_write("wr_decerr_wins", 4'h3, BASE - 32'd4, 4'd1, 3'd2, 2'b01, -1, 1);
    do_read("wr_edge_check", 4'h0, BASE + 32'h30, 4'd1, 3'd2, 2'b01, -1, 0);
  endtask

  task automatic test_reset_mid;
    int t_hs, waited;
    bit ok;
    ar_send(4'h6, BASE + 32'h60, 4'd3, 3'd2, 2'b01, t_hs, ok);
    rready = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!rvalid && waited < 20) begin @(negedge clk); waited++; end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({rvalid, arready, awready, wready, bvalid, mem_en} !== 6'd0 || dbg_state !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_read got vld/rdy=%b state=%0d want 000000 state=0",
               {rvalid, arready, awready, wready, bvalid, mem_en}, dbg_state);
    end
    @(posedge clk); #1;
    do_read("after_rst_read", 4'hB, BASE + 32'h60, 4'd1, 3'd2, 2'b01, -1, 0);
    aw_send(4'h7, BASE + 32'h70, 4'd3, 3'd2, 2'b01, ok);
    @(negedge clk);
    tests_run++;
    if (wready !== 1'b1 || dbg_state !== 3'd4) begin
      tests_failed++; $display("FAIL wr_data_entry got wready=%0d state=%0d want 1/4", wready, dbg_state);
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({rvalid, arready, awready, wready, bvalid, mem_en} !== 6'd0 || dbg_state !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_write got vld/rdy=%b state=%0d want 000000 state=0",
               {rvalid, arready, awready, wready, bvalid, mem_en}, dbg_state);
    end
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin w_data[b] = $urandom; w_strb[b] = 4'hF; end
    do_write("after_rst_write", 4'h7, BASE + 32'h70, 4'd1, 3'd2, 2'b01, -1, -1);
    do_read("after_rst_check", 4'h7, BASE + 32'h70, 4'd1, 3'd2, 2'b01, -1, 0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [3:0] len;
    logic [2:0] sz;
    logic [1:0] bu;
    int mode, sb;
    for (int n = 0; n < 30; n++) begin
      mode = $urandom_range(0, 7);
      if (mode <= 5)      a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
      else if (mode == 6) a = BASE + SPAN_B - 32'(4 * $urandom_range(1, 3));
      else                a = BASE - 32'(4 * $urandom_range(1, 3));
      len = 4'($urandom_range(0, 7));
      sz  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
      bu  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        sb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(len)) : -1;
        do_read("rand_read", 4'($urandom_range(0, 15)), a, len, sz, bu, sb, $urandom_range(1, 4));
      end else begin
        for (int b = 0; b < 16; b++) begin w_data[b] = $urandom; w_strb[b] = 4'($urandom_range(0, 15)); end
        do_write("rand_write", 4'($urandom_range(0, 15)), a, len, sz, bu,
                 ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(len)) : -1,
                 ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(len)) : -1);
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    init_inputs();
    reset = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      v = $urandom;
      sram[i] = v;
      ref_mem[i] = v;
    end
    test_reset();
    test_read_basic();
    test_write_strobe();
    test_stall();
    test_arbitration();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
